// File: rtl/step_sequencer_if.sv
// Signal bundle between the instruction phase controller and the datapath/decoder.
// The sequencer uses the slave modport and the driving side uses the master modport.
interface step_sequencer_if;
  logic       run;
  logic       step_req;
  logic       is_mem_op;
  logic       is_halt;
  logic       mem_ready;
  logic [4:0] step;
  logic       mem_req;
  logic       pc_en;
  logic       rf_we;
  logic       instr_done;
  logic       busy;
  logic       halted;
  logic       mem_timeout;

  modport master (
    output run, step_req, is_mem_op, is_halt, mem_ready,
    input  step, mem_req, pc_en, rf_we, instr_done, busy, halted, mem_timeout
  );

  modport slave (
    input  run, step_req, is_mem_op, is_halt, mem_ready,
    output step, mem_req, pc_en, rf_we, instr_done, busy, halted, mem_timeout
  );
endinterface

// File: rtl/step_sequencer.sv
// Multi-cycle instruction phase controller: FETCH/DECODE/EXEC/MEM/WB with a clock-enable
// divider, memory wait with timeout fault, HALT handling and single-step debug.
module step_sequencer #(
  parameter int DIV_LOG2 = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  step_sequencer_if.slave  bus
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic            w_tick;
  logic            w_to_fire;
  logic            w_start;
  logic            r_step_pend;
  logic            r_mem_rdy;
  logic            r_mem_timeout;
  logic [TO_W-1:0] r_to_cnt;

  // Phase advance enable: every clk when undivided, else when the divider is all ones.
  if (DIV_LOG2 == 0) begin : g_nodiv
    assign w_tick = 1'b1;
  end else begin : g_div
    logic [DIV_LOG2-1:0] r_div;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_div <= '0;
      else          r_div <= r_div + DIV_LOG2'(1);
    end

    assign w_tick = &r_div;
  end

  // The timeout fault is the only transition that does not wait for a tick.
  assign w_to_fire = (r_state == S_MEM) && !r_mem_rdy && !bus.mem_ready &&
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  assign w_start = (r_state == S_IDLE) && (w_next == S_FETCH);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    if (w_to_fire) begin
      w_next = S_HALT;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE:   if (bus.run || r_step_pend) w_next = S_FETCH;
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: w_next = bus.is_halt ? S_HALT : S_EXEC;
        S_EXEC:   w_next = bus.is_mem_op ? S_MEM : S_WB;
        S_MEM:    if (r_mem_rdy || bus.mem_ready) w_next = S_WB;
        S_WB:     w_next = bus.run ? S_FETCH : S_IDLE;
        S_HALT:   w_next = S_HALT;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.step       = 5'b00000;
    bus.mem_req    = 1'b0;
    bus.pc_en      = 1'b0;
    bus.rf_we      = 1'b0;
    bus.instr_done = 1'b0;
    bus.halted     = 1'b0;
    case (r_state)
      S_FETCH:  bus.step = 5'b00001;
      S_DECODE: bus.step = 5'b00010;
      S_EXEC:   bus.step = 5'b00100;
      S_MEM: begin
        bus.step    = 5'b01000;
        bus.mem_req = 1'b1;
      end
      S_WB: begin
        bus.step       = 5'b10000;
        bus.pc_en      = w_tick;
        bus.rf_we      = w_tick;
        bus.instr_done = w_tick;
      end
      S_HALT:   bus.halted = 1'b1;
      default:  bus.step = 5'b00000;
    endcase
  end

  assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign bus.mem_timeout = r_mem_timeout;

  // A single pending debug step; later pulses while one is pending are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_pend <= 1'b0;
    end else if (w_start) begin
      r_step_pend <= 1'b0;
    end else if (bus.step_req && !bus.run && (r_state != S_HALT)) begin
      r_step_pend <= 1'b1;
    end
  end

  // mem_ready latch and wait counter live only while the FSM stays in MEM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_rdy <= 1'b0;
      r_to_cnt  <= '0;
    end else if ((r_state == S_MEM) && (w_next == S_MEM)) begin
      if (bus.mem_ready) r_mem_rdy <= 1'b1;
      if (!r_mem_rdy)    r_to_cnt  <= r_to_cnt + TO_W'(1);
    end else begin
      r_mem_rdy <= 1'b0;
      r_to_cnt  <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_mem_timeout <= 1'b0;
    else if (w_to_fire) r_mem_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a phase-trace scoreboard is filled when instructions are
// launched and drained on every instr_done, plus cycle-exact checks around ticks, MEM and reset.
module tb_step_sequencer;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;
  int   n_pc     = 0;
  int   n_rf     = 0;
  int   cyc      = 0;

  logic [31:0] sb[$];
  logic [31:0] trace;
  logic [4:0]  last_step;

  logic [4:0] t1_step [11] = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd4, 5'd4, 5'd16, 5'd16, 5'd1, 5'd1};
  logic       t1_done [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  step_sequencer_if bif ();

  step_sequencer #(.DIV_LOG2(1), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_sig(input logic mem);
    logic [31:0] s;
    s = 32'd1;
    s = (s << 5) | 32'd2;
    s = (s << 5) | 32'd4;
    if (mem) s = (s << 5) | 32'd8;
    s = (s << 5) | 32'd16;
    return s;
  endfunction

  task automatic wait_done(input int max_cyc, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bif.instr_done && k < max_cyc);
    check(tag, 32'(bif.instr_done), 32'd1);
  endtask

  task automatic wait_step(input logic [4:0] val, input int max_cyc, input string tag);
    int k = 0;
    while (bif.step !== val && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bif.step), 32'(val));
  endtask

  task automatic wait_halt(input int max_cyc, input string tag);
    int k = 0;
    while (bif.halted !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bif.halted), 32'd1);
  endtask

  task automatic pulse_step_req();
    bif.step_req = 1'b1;
    @(negedge clk);
    bif.step_req = 1'b0;
  endtask

  // Monitor: builds the phase trace of each instruction and pops the expected one on retire.
  always @(negedge clk) begin
    if (!reset_n) begin
      trace     = '0;
      last_step = '0;
    end else begin
      if (bif.step == 5'b00001 && last_step != 5'b00001) trace = 32'd1;
      else if (bif.step != 5'b0 && bif.step != last_step) trace = (trace << 5) | 32'(bif.step);
      last_step = bif.step;
      if (bif.instr_done || bif.pc_en || bif.rf_we) begin
        check("strobes_together", 32'({bif.pc_en, bif.rf_we, bif.instr_done}), 32'd7);
        check("strobe_in_wb", 32'(bif.step), 32'd16);
      end
      if (bif.instr_done) begin
        n_done++;
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("sb_phase_trace", trace, sb.pop_front());
      end
      if (bif.pc_en) n_pc++;
      if (bif.rf_we) n_rf++;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t_done;
    int base;
    bif.run       = 1'b0;
    bif.step_req  = 1'b0;
    bif.is_mem_op = 1'b0;
    bif.is_halt   = 1'b0;
    bif.mem_ready = 1'b0;
    reset_n       = 1'b0;
    t_done        = 0;
    repeat (3) @(negedge clk);
    check("rst_step", 32'(bif.step), 32'd0);
    check("rst_outs", 32'({bif.mem_req, bif.pc_en, bif.rf_we, bif.instr_done,
                           bif.busy, bif.halted, bif.mem_timeout}), 32'd0);

    // 1: continuous run, no memory ops; run dropped during the third instruction
    repeat (3) sb.push_back(mk_sig(1'b0));
    bif.run = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("t1_step[%0d]", i), 32'(bif.step), 32'(t1_step[i]));
      check($sformatf("t1_done[%0d]", i), 32'(bif.instr_done), 32'(t1_done[i]));
      check("t1_mem_req", 32'(bif.mem_req), 32'd0);
      if (i == 8) t_done = cyc;
    end
    wait_done(20, "t1_done2");
    check("t1_gap2", 32'(cyc - t_done), 32'd8);
    t_done = cyc;
    repeat (2) @(negedge clk);
    bif.run = 1'b0;
    wait_done(20, "t1_done3");
    check("t1_gap3", 32'(cyc - t_done), 32'd8);
    repeat (6) @(negedge clk);
    check("t1_idle_busy", 32'(bif.busy), 32'd0);
    check("t1_idle_step", 32'(bif.step), 32'd0);
    check("t1_done_count", 32'(n_done), 32'd3);

    // 2: single-stepped memory instruction, mem_ready pulses mid-MEM
    bif.is_mem_op = 1'b1;
    sb.push_back(mk_sig(1'b1));
    @(negedge clk);
    pulse_step_req();
    wait_step(5'b01000, 40, "t2_mem_enter");
    check("t2_mem_req", 32'(bif.mem_req), 32'd1);
    @(negedge clk);
    check("t2_mem_hold1", 32'(bif.step), 32'd8);
    @(negedge clk);
    check("t2_mem_hold2", 32'(bif.step), 32'd8);
    bif.mem_ready = 1'b1;
    @(negedge clk);
    bif.mem_ready = 1'b0;
    check("t2_mem_hold3", 32'(bif.step), 32'd8);
    check("t2_mem_req3", 32'(bif.mem_req), 32'd1);
    @(negedge clk);
    check("t2_wb_step", 32'(bif.step), 32'd16);
    check("t2_wb_mem_req", 32'(bif.mem_req), 32'd0);
    check("t2_wb_no_strobe", 32'(bif.rf_we), 32'd0);
    @(negedge clk);
    check("t2_wb_rf_we", 32'(bif.rf_we), 32'd1);
    repeat (4) @(negedge clk);
    check("t2_idle_busy", 32'(bif.busy), 32'd0);
    check("t2_done_count", 32'(n_done), 32'd4);

    // 3: memory never ready -> timeout fault and terminal HALT
    base = n_rf;
    pulse_step_req();
    wait_step(5'b01000, 40, "t3_mem_enter");
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      check($sformatf("t3_wait_step[%0d]", k), 32'(bif.step), 32'd8);
      check($sformatf("t3_wait_halt[%0d]", k), 32'(bif.halted), 32'd0);
    end
    @(negedge clk);
    check("t3_halted", 32'(bif.halted), 32'd1);
    check("t3_timeout", 32'(bif.mem_timeout), 32'd1);
    check("t3_step", 32'(bif.step), 32'd0);
    check("t3_busy", 32'(bif.busy), 32'd0);
    bif.run = 1'b1;
    pulse_step_req();
    repeat (10) @(negedge clk);
    check("t3_still_halted", 32'(bif.halted), 32'd1);
    check("t3_sticky", 32'(bif.mem_timeout), 32'd1);
    check("t3_no_rf_we", 32'(n_rf - base), 32'd0);
    bif.run = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t3_rst_timeout", 32'(bif.mem_timeout), 32'd0);
    check("t3_rst_halted", 32'(bif.halted), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 4: two debug steps plus a dropped extra pulse
    bif.is_mem_op = 1'b0;
    base = n_done;
    repeat (2) sb.push_back(mk_sig(1'b0));
    @(negedge clk);
    pulse_step_req();
    wait_step(5'b00010, 40, "t4_decode");
    pulse_step_req();
    wait_step(5'b00100, 40, "t4_exec");
    pulse_step_req();
    wait_done(40, "t4_done1");
    wait_done(40, "t4_done2");
    repeat (30) @(negedge clk);
    check("t4_done_count", 32'(n_done - base), 32'd2);
    check("t4_busy", 32'(bif.busy), 32'd0);
    check("t4_step", 32'(bif.step), 32'd0);

    // 5: HALT decoded with run high
    base = n_pc;
    bif.is_halt = 1'b1;
    bif.run     = 1'b1;
    wait_halt(40, "t5_halted");
    check("t5_step", 32'(bif.step), 32'd0);
    repeat (50) @(negedge clk);
    check("t5_still_halted", 32'(bif.halted), 32'd1);
    check("t5_no_pc_en", 32'(n_pc - base), 32'd0);
    #3;
    reset_n = 1'b0;
    #1;
    check("t5_rst_halted", 32'(bif.halted), 32'd0);
    check("t5_rst_busy", 32'(bif.busy), 32'd0);
    bif.is_halt   = 1'b0;
    bif.is_mem_op = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // 6: asynchronous reset while waiting in MEM
    wait_step(5'b01000, 40, "t6_mem_enter");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_step", 32'(bif.step), 32'd0);
    check("t6_async_mem_req", 32'(bif.mem_req), 32'd0);
    check("t6_async_busy", 32'(bif.busy), 32'd0);
    bif.is_mem_op = 1'b0;
    sb.push_back(mk_sig(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_first_cycle_idle", 32'(bif.step), 32'd0);
    @(negedge clk);
    check("t6_first_tick_fetch", 32'(bif.step), 32'd1);
    bif.run = 1'b0;
    wait_done(20, "t6_done");
    repeat (6) @(negedge clk);
    check("t6_busy", 32'(bif.busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
